// File: rtl/sdcmd_engine_if.sv
// Host-side and SPI-side signals of the SD SPI-mode command engine.
// The engine uses the slave view; its environment uses the master view.
`timescale 1ns/1ps
interface sdcmd_engine_if #(
  parameter int MAX_RESP_BYTES = 5
);
  logic                        w_cmd;
  logic [5:0]                  cmd_index;
  logic [31:0]                 argument;
  logic [6:0]                  crc_in;
  logic [3:0]                  resp_len;
  logic                        resp_busy;
  logic [8*MAX_RESP_BYTES-1:0] response;
  logic                        busy;
  logic                        done;
  logic                        timeout;
  logic [7:0]                  spi_out_sdcmd_in;
  logic [7:0]                  spi_in_sdcmd_out;
  logic                        spi_busy;
  logic                        w_spi_data;
  logic                        cs_spi;

  modport master (
    output w_cmd, cmd_index, argument, crc_in,
    output resp_len, resp_busy,
    output spi_out_sdcmd_in, spi_busy,
    input  response, busy, done, timeout,
    input  spi_in_sdcmd_out, w_spi_data, cs_spi
  );

  modport slave (
    input  w_cmd, cmd_index, argument, crc_in,
    input  resp_len, resp_busy,
    input  spi_out_sdcmd_in, spi_busy,
    output response, busy, done, timeout,
    output spi_in_sdcmd_out, w_spi_data, cs_spi
  );
endinterface

// File: rtl/sdcmd_engine.sv
// SD SPI-mode command engine: frame + CRC7 send, NCR poll,
// response read, optional R1b busy wait, trailing byte.
`timescale 1ns/1ps
module sdcmd_engine #(
  parameter int MAX_RESP_BYTES = 5,
  parameter int NCR_MAX        = 8,
  parameter int BUSY_MAX       = 65535,
  parameter bit CRC_AUTO       = 1'b1
) (
  input logic           clk,
  input logic           reset,
  sdcmd_engine_if.slave bus
);
  localparam int MR   = MAX_RESP_BYTES;
  localparam int RW   = 8 * MR;
  localparam int M1   = (NCR_MAX > 6) ? NCR_MAX : 6;
  localparam int CMAX = (BUSY_MAX > M1) ? BUSY_MAX : M1;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_POLL, S_READ, S_BUSYW, S_FIN
  } state_t;

  typedef enum logic [1:0] {
    P_STB, P_GAP, P_WAIT
  } ph_t;

  state_t          r_state, w_state_nx;
  ph_t             r_ph, w_ph_nx;
  logic [CW-1:0]   r_cnt, w_cnt_nx, w_cnt_inc, w_widx;
  logic [39:0]     r_frame;
  logic [7:0]      r_tx;
  logic [3:0]      r_len, w_len;
  logic            r_rbusy;
  logic [RW-1:0]   r_resp;
  logic            r_to, r_done;
  logic            w_cap, w_latch, w_store, w_set_to;
  logic            w_ncr_to, w_fin;
  logic            w_busy, w_cs, w_strobe;
  logic [7:0]      w_rx;
  logic [6:0]      w_crc;

  function automatic logic [6:0] f_crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign w_rx      = bus.spi_out_sdcmd_in;
  assign w_cap     = (r_ph == P_WAIT) && !bus.spi_busy;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_crc     = CRC_AUTO
    ? f_crc7({2'b01, bus.cmd_index, bus.argument})
    : bus.crc_in;
  assign w_len = (bus.resp_len == 4'd0 ||
                  int'(bus.resp_len) > MR)
    ? 4'(MR) : bus.resp_len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ph    <= P_STB;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ph    <= w_ph_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ph_nx    = r_ph;
    w_cnt_nx   = r_cnt;
    w_widx     = r_cnt;
    w_latch    = 1'b0;
    w_store    = 1'b0;
    w_set_to   = 1'b0;
    w_ncr_to   = 1'b0;
    w_fin      = 1'b0;
    // Byte handshake: strobe, skip busy-rise cycle, wait idle.
    if (r_state != S_IDLE) begin
      unique case (r_ph)
        P_STB:   if (!bus.spi_busy) w_ph_nx = P_GAP;
        P_GAP:   w_ph_nx = P_WAIT;
        P_WAIT:  if (w_cap) w_ph_nx = P_STB;
        default: w_ph_nx = P_STB;
      endcase
    end
    unique case (r_state)
      S_IDLE: if (bus.w_cmd) begin
        w_latch    = 1'b1;
        w_state_nx = S_SEND;
        w_ph_nx    = P_STB;
        w_cnt_nx   = '0;
      end
      S_SEND: if (w_cap) begin
        if (r_cnt == CW'(5)) begin
          w_state_nx = S_POLL;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_POLL: if (w_cap) begin
        if (!w_rx[7]) begin
          w_store  = 1'b1;
          w_widx   = '0;
          w_cnt_nx = CW'(1);
          if (r_len == 4'd1) begin
            w_state_nx = r_rbusy ? S_BUSYW : S_FIN;
            w_cnt_nx   = '0;
          end else begin
            w_state_nx = S_READ;
          end
        end else if (r_cnt == CW'(NCR_MAX - 1)) begin
          w_set_to   = 1'b1;
          w_ncr_to   = 1'b1;
          w_state_nx = S_FIN;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_READ: if (w_cap) begin
        w_store = 1'b1;
        if (int'(r_cnt) == int'(r_len) - 1) begin
          w_state_nx = r_rbusy ? S_BUSYW : S_FIN;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_BUSYW: if (w_cap) begin
        if (w_rx != 8'h00) begin
          w_state_nx = S_FIN;
        end else if (r_cnt == CW'(BUSY_MAX - 1)) begin
          w_set_to   = 1'b1;
          w_state_nx = S_FIN;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_FIN: if (w_cap) begin
        w_state_nx = S_IDLE;
        w_fin      = 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_cs     = (r_state == S_IDLE);
    w_strobe = w_busy && (r_ph == P_STB) && !bus.spi_busy;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame <= '0;
      r_tx    <= 8'hFF;
      r_len   <= '0;
      r_rbusy <= 1'b0;
      r_resp  <= '0;
      r_to    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_latch) begin
        r_frame <= {bus.argument, w_crc, 1'b1};
        r_tx    <= {2'b01, bus.cmd_index};
        r_len   <= w_len;
        r_rbusy <= bus.resp_busy;
        r_resp  <= '0;
        r_to    <= 1'b0;
      end else if (w_cap) begin
        if (r_state == S_SEND && r_cnt != CW'(5)) begin
          r_tx    <= r_frame[39:32];
          r_frame <= {r_frame[31:0], 8'h00};
        end else begin
          r_tx <= 8'hFF;
        end
      end
      if (w_store) begin
        for (int i = 0; i < MR; i++) begin
          if (int'(w_widx) == i)
            r_resp[RW-1-8*i -: 8] <= w_rx;
        end
      end
      if (w_ncr_to) r_resp[RW-1 -: 8] <= 8'hFF;
      if (w_set_to) r_to <= 1'b1;
    end
  end

  assign bus.busy             = w_busy;
  assign bus.cs_spi           = w_cs;
  assign bus.w_spi_data       = w_strobe;
  assign bus.spi_in_sdcmd_out = r_tx;
  assign bus.response         = r_resp;
  assign bus.timeout          = r_to;
  assign bus.done             = r_done;
endmodule

// File: tb/tb_sdcmd_engine.sv
// Bench for sdcmd_engine: SPI card model, transaction-level
// reference model and per-cycle compare.
`timescale 1ns/1ps
module tb_sdcmd_engine;
  localparam int MR   = 5;
  localparam int NCR  = 8;
  localparam int BMAX = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sdcmd_engine_if #(.MAX_RESP_BYTES(MR)) bus();

  sdcmd_engine #(
    .MAX_RESP_BYTES(MR),
    .NCR_MAX(NCR),
    .BUSY_MAX(BMAX),
    .CRC_AUTO(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int ntx    = 0;
  logic [7:0]  card_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic [39:0] exp_resp = '0;
  logic        exp_to   = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, req);
  endtask

  // Reference CRC7 by polynomial long division.
  function automatic logic [6:0] crc_ref(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  function automatic logic [7:0] card_at(input int k);
    if (k < card_q.size()) return card_q[k];
    return 8'hFF;
  endfunction

  function automatic logic [47:0] log6();
    logic [47:0] v;
    v = '0;
    for (int i = 0; i < 6; i++)
      v = {v[39:0], (i < tx_log.size()) ? tx_log[i] : 8'h00};
    return v;
  endfunction

  // Walk the card's byte script the way a command unfolds.
  task automatic model(input logic [5:0] idx, input logic [31:0] arg,
                       input logic [3:0] len, input logic rb);
    logic [39:0] hdr;
    logic [7:0]  b;
    logic        got, ok;
    int          eff, k, n;
    hdr = {2'b01, idx, arg};
    exp_tx.delete();
    for (int i = 0; i < 5; i++) exp_tx.push_back(hdr[39-8*i -: 8]);
    exp_tx.push_back({crc_ref(hdr), 1'b1});
    eff = (len == 0 || len > MR) ? MR : int'(len);
    exp_resp = '0;
    exp_to   = 1'b0;
    k = 0; n = 0; got = 1'b0;
    for (int p = 0; p < NCR && !got; p++) begin
      b = card_at(k); k++; n++;
      if (!b[7]) begin
        got = 1'b1;
        exp_resp[39 -: 8] = b;
      end
    end
    if (!got) begin
      exp_to = 1'b1;
      exp_resp[39 -: 8] = 8'hFF;
    end else begin
      for (int i = 1; i < eff; i++) begin
        exp_resp[39-8*i -: 8] = card_at(k); k++; n++;
      end
      if (rb) begin
        ok = 1'b0;
        for (int p = 0; p < BMAX && !ok; p++) begin
          b = card_at(k); k++; n++;
          if (b != 8'h00) ok = 1'b1;
        end
        if (!ok) exp_to = 1'b1;
      end
    end
    n++;
    repeat (n) exp_tx.push_back(8'hFF);
  endtask

  // SPI master + card: busy for 1..3 cycles per byte.
  initial begin
    logic [7:0] sb;
    int         lat;
    bus.spi_busy         = 1'b0;
    bus.spi_out_sdcmd_in = 8'hFF;
    forever begin
      @(negedge clk);
      if (bus.w_spi_data) begin
        tx_log.push_back(bus.spi_in_sdcmd_out);
        if (rx_q.size() > 0) sb = rx_q.pop_front();
        else sb = 8'hFF;
        lat = 1 + (ntx % 3);
        ntx++;
        @(posedge clk); #1;
        bus.spi_busy = 1'b1;
        repeat (lat) @(posedge clk);
        #1;
        bus.spi_busy         = 1'b0;
        bus.spi_out_sdcmd_in = sb;
      end
    end
  end

  initial begin
    logic prev_stb, prev_done;
    prev_stb  = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      chk("cs_vs_busy", bus.cs_spi, !bus.busy);
      if (bus.w_spi_data) begin
        chk("strobe_rule", {prev_stb, bus.spi_busy}, 2'b00);
        chk("tx_pending", exp_tx.size() > 0, 1);
        if (exp_tx.size() > 0)
          chk("tx_byte", bus.spi_in_sdcmd_out, exp_tx.pop_front());
      end
      if (bus.done) begin
        chk("resp", bus.response, exp_resp);
        chk("timeout", bus.timeout, exp_to);
        chk("done_idle", {bus.busy, bus.cs_spi}, 2'b01);
        chk("tx_all_sent", exp_tx.size(), 0);
        chk("done_single", prev_done, 0);
      end
      prev_stb  = bus.w_spi_data;
      prev_done = bus.done;
    end
  end

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [3:0] len, input logic rb);
    @(negedge clk);
    chk("resp_hold", bus.response, exp_resp);
    chk("to_hold", bus.timeout, exp_to);
    model(idx, arg, len, rb);
    rx_q.delete();
    repeat (6) rx_q.push_back(8'hFF);
    foreach (card_q[i]) rx_q.push_back(card_q[i]);
    tx_log.delete();
    bus.cmd_index = idx;
    bus.argument  = arg;
    bus.resp_len  = len;
    bus.resp_busy = rb;
    bus.w_cmd     = 1'b1;
    @(negedge clk);
    bus.w_cmd = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_strobe", bus.w_spi_data, 1);
    repeat (3) @(negedge clk);
    bus.cmd_index = 6'h3F;
    bus.argument  = 32'hFFFF_FFFF;
    bus.resp_len  = 4'd2;
    bus.resp_busy = !rb;
    bus.w_cmd     = 1'b1;
    @(negedge clk);
    bus.w_cmd = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (c < 3000 && !bus.done) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", bus.done, 1);
    @(negedge clk);
    chk("done_end", {bus.done, bus.busy}, 2'b00);
  endtask

  initial begin
    int c;
    bus.w_cmd     = 1'b0;
    bus.cmd_index = '0;
    bus.argument  = '0;
    bus.crc_in    = '0;
    bus.resp_len  = 4'd1;
    bus.resp_busy = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_to", bus.timeout, 0);
    chk("rst_strobe", bus.w_spi_data, 0);
    chk("rst_cs", bus.cs_spi, 1);
    chk("rst_tx", bus.spi_in_sdcmd_out, 8'hFF);
    chk("rst_resp", bus.response, 0);
    #20 reset = 1'b1;
    repeat (2) @(negedge clk);

    card_q = '{8'hFF, 8'h01};
    start_cmd(6'd0, 32'h0, 4'd1, 1'b0);
    wait_done();
    chk("cmd0_frame", log6(), 48'h40_00_00_00_00_95);
    chk("cmd0_r1", bus.response[39:32], 8'h01);
    chk("cmd0_strobes", tx_log.size(), 9);

    card_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    start_cmd(6'd8, 32'h0000_01AA, 4'd5, 1'b0);
    wait_done();
    chk("cmd8_crc", tx_log[5], 8'h87);
    chk("cmd8_resp", bus.response, 40'h01_00_00_01_AA);

    card_q.delete();
    start_cmd(6'd17, 32'h0000_0200, 4'd1, 1'b0);
    wait_done();
    chk("ncr_strobes", tx_log.size(), 15);
    chk("ncr_to", bus.timeout, 1);
    chk("ncr_byte0", bus.response[39:32], 8'hFF);

    card_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF,
               8'hFF, 8'hFF, 8'hFF, 8'h05};
    start_cmd(6'd55, 32'h0, 4'd1, 1'b0);
    wait_done();
    chk("ncr_edge_resp", bus.response[39:32], 8'h05);
    chk("ncr_edge_to", bus.timeout, 0);

    card_q = '{8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00};
    start_cmd(6'd58, 32'h0, 4'd0, 1'b0);
    wait_done();
    chk("len0_resp", bus.response, 40'h00_C0_FF_80_00);

    card_q = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    start_cmd(6'd12, 32'h0, 4'd1, 1'b1);
    wait_done();
    chk("r1b_strobes", tx_log.size(), 13);
    chk("r1b_to", bus.timeout, 0);

    card_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    start_cmd(6'd38, 32'h0, 4'd1, 1'b1);
    wait_done();
    chk("busy_to_strobes", tx_log.size(), 12);
    chk("busy_to", bus.timeout, 1);

    card_q = '{8'hFF, 8'h01};
    start_cmd(6'd0, 32'h0, 4'd1, 1'b0);
    c = 0;
    while (c < 200 && tx_log.size() < 4) begin
      @(negedge clk);
      c++;
    end
    chk("rst_reach_b3", tx_log.size() >= 4, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("arst_cs", bus.cs_spi, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_strobe", bus.w_spi_data, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_tx", bus.spi_in_sdcmd_out, 8'hFF);
    exp_tx.delete();
    exp_resp = '0;
    exp_to   = 1'b0;
    #15 reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_no_done", bus.done, 0);

    card_q = '{8'hFF, 8'h01};
    start_cmd(6'd0, 32'h0, 4'd1, 1'b0);
    wait_done();
    chk("post_rst_frame", log6(), 48'h40_00_00_00_00_95);
    chk("post_rst_r1", bus.response[39:32], 8'h01);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
